// File: rtl/press_pulse_gen.sv
// -----------------------------------------------------------------------------
// press_pulse_gen
//   Transmit side of the press/edge-detect interface. Each accepted single-cycle
//   request on trig becomes a level pulse on out: high for HIGH_CYCLES, then low
//   for at least LOW_CYCLES. That spacing lets a downstream 2-flop synchronizer
//   plus rising-edge detector see exactly one press per accepted request.
//
//   Optional feature, enabled by defining the macro PRESS_QUEUE_EN:
//     requests arriving while a press is in progress are held in a backlog
//     counter (up to MAX_PENDING) instead of being dropped. Without the macro
//     pending is tied to 0 and every request that arrives while busy is dropped.
// -----------------------------------------------------------------------------
module press_pulse_gen #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int MAX_PENDING = 3,
  parameter int PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              reset,    // asynchronous, active-low
  input  logic              trig,
  output logic              out,
  output logic              busy,
  output logic              dropped,
  output logic [PEND_W-1:0] pending
);

  // The timer is shared by both phases, so it must hold the longer one.
  localparam int TMAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]     T_HIGH   = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]     T_LOW    = TW'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e              state_q;
  logic [TW-1:0]       timer_q;
  logic                out_q;
  logic                busy_q;
  logic                dropped_q;
  logic [PEND_W-1:0]   pending_q;

  logic                gap_exit;
  logic                late_trig;

  // Decode the last GAP cycle and requests that arrive while a press runs.
  always_comb begin
    gap_exit  = (state_q == ST_GAP) && (timer_q == '0);
    // On the GAP-exit cycle a new request is taken directly, never as "late".
    late_trig = trig && (state_q != ST_IDLE) && !gap_exit;
  end

  // Press sequencer plus backlog / drop bookkeeping, all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
      pending_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q <= ST_HIGH;
            timer_q <= T_HIGH;
            out_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else begin
            state_q <= ST_GAP;
            timer_q <= T_LOW;
            out_q   <= 1'b0;
          end
        end

        ST_GAP: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else if ((pending_q != '0) || trig) begin
            // Back-to-back press: no IDLE cycle, busy stays high.
            state_q <= ST_HIGH;
            timer_q <= T_HIGH;
            out_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      // NOTE: default-then-override; a later non-blocking assignment to the
      // same register in this block wins, giving a one-cycle pulse.
      dropped_q <= 1'b0;

`ifdef PRESS_QUEUE_EN
      if (late_trig) begin
        if (pending_q < PEND_MAX) begin
          pending_q <= pending_q + PEND_W'(1);
        end else begin
          dropped_q <= 1'b1;
        end
      end else if (gap_exit && (pending_q != '0) && !trig) begin
        // Dequeue only; with trig also present the dequeue and the enqueue
        // cancel and the count holds.
        pending_q <= pending_q - PEND_W'(1);
      end
`else
      dropped_q <= late_trig;
`endif
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_press_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_press_pulse_gen
//   Two instances: dut_a with default parameters and dut_b with LOW_CYCLES=3
//   and MAX_PENDING=5. dut_b also feeds a 2-flop synchronizer plus a rising-edge
//   detector. Expected behaviour comes from a timeline model. Each press is
//   described by its start cycle s: out is high in cycles s+1..s+H, and busy
//   stays high through cycle s+H+L. A new press may start in any cycle at or
//   after s+H+L. Build with or without +define+PRESS_QUEUE_EN.
// -----------------------------------------------------------------------------
module tb_press_pulse_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trig_a = 1'b0;
  logic       trig_b = 1'b0;
  logic       out_a, busy_a, drop_a;
  logic [1:0] pend_a;
  logic       out_b, busy_b, drop_b;
  logic [2:0] pend_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  press_pulse_gen dut_a (
    .clk     (clk),
    .reset   (reset),
    .trig    (trig_a),
    .out     (out_a),
    .busy    (busy_a),
    .dropped (drop_a),
    .pending (pend_a)
  );

  press_pulse_gen #(
    .LOW_CYCLES  (3),
    .MAX_PENDING (5)
  ) dut_b (
    .clk     (clk),
    .reset   (reset),
    .trig    (trig_b),
    .out     (out_b),
    .busy    (busy_b),
    .dropped (drop_b),
    .pending (pend_b)
  );

  // Receiver model: 2-flop synchronizer followed by a rising-edge detector.
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic det_arm = 1'b0;
  int   tick = 0;
  int   pulse_q[$];

  always @(posedge clk) begin
    if (det_arm && s2 && !s3) pulse_q.push_back(tick);
    s1   <= out_b;
    s2   <= s1;
    s3   <= s2;
    tick <= tick + 1;
  end

  // ---------------- reference model (timeline of press start cycles) --------
  int m_h[2]   = '{4, 4};
  int m_l[2]   = '{4, 3};
  int m_max[2] = '{3, 5};
  bit m_started[2];
  int m_last_s[2];
  int m_pend[2];
  bit m_drop[2];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 1'b0;
      m_last_s[k]  = 0;
      m_pend[k]    = 0;
      m_drop[k]    = 1'b0;
    end
  endtask

  // Apply request t seen in cycle cyc to instance k.
  task automatic model_step(input int k, input bit t);
    int free_at;
    free_at  = m_last_s[k] + m_h[k] + m_l[k];
    m_drop[k] = 1'b0;
    if (!m_started[k] || cyc >= free_at) begin
      if (m_pend[k] > 0) begin
        m_started[k] = 1'b1;
        m_last_s[k]  = cyc;
        if (!t) m_pend[k]--;
      end else if (t) begin
        m_started[k] = 1'b1;
        m_last_s[k]  = cyc;
      end
    end else if (t) begin
`ifdef PRESS_QUEUE_EN
      if (m_pend[k] < m_max[k]) m_pend[k]++;
      else m_drop[k] = 1'b1;
`else
      m_drop[k] = 1'b1;
`endif
    end
  endtask

  function automatic int exp_out(input int k);
    return (m_started[k] && cyc > m_last_s[k] && cyc <= m_last_s[k] + m_h[k]) ? 1 : 0;
  endfunction

  function automatic int exp_busy(input int k);
    return (m_started[k] && cyc > m_last_s[k] &&
            cyc <= m_last_s[k] + m_h[k] + m_l[k]) ? 1 : 0;
  endfunction

  task automatic check_all();
    check("a_out",     int'(out_a),  exp_out(0));
    check("a_busy",    int'(busy_a), exp_busy(0));
    check("a_dropped", int'(drop_a), int'(m_drop[0]));
    check("a_pending", int'(pend_a), m_pend[0]);
    check("b_out",     int'(out_b),  exp_out(1));
    check("b_busy",    int'(busy_b), exp_busy(1));
    check("b_dropped", int'(drop_b), int'(m_drop[1]));
    check("b_pending", int'(pend_b), m_pend[1]);
  endtask

  // Called at a negedge: drive requests, let the edge sample them, check.
  task automatic step(input bit ta, input bit tb);
    trig_a = ta;
    trig_b = tb;
    @(posedge clk);
    model_step(0, ta);
    model_step(1, tb);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic run_seq(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) step(pat[i], pat[i]);
    idle(40);
  endtask

`ifdef PRESS_QUEUE_EN
  localparam int CL_PRESSES = 5;
`else
  localparam int CL_PRESSES = 1;
`endif

  initial begin
    model_reset();

    // Asynchronous reset assertion, checked before any clock edge.
    #3 reset = 1'b0;
    #1;
    check("rst_out",     int'(out_a),  0);
    check("rst_busy",    int'(busy_a), 0);
    check("rst_dropped", int'(drop_a), 0);
    check("rst_pending", int'(pend_a), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();

    // Directed patterns (bit i = request in relative cycle i).
    run_seq(16'h0001, 1);   // single press
    run_seq(16'h0009, 4);   // second request lands in HIGH
    run_seq(16'h0101, 9);   // request on the GAP-exit cycle of dut_a
    run_seq(16'h003D, 6);   // backlog fills, last request overflows
    run_seq(16'h00FF, 8);   // request held high for 8 cycles

    // Reset pulled mid-press, between clock edges.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_a_out",  int'(out_a),  0);
    check("mid_rst_a_busy", int'(busy_a), 0);
    check("mid_rst_b_out",  int'(out_b),  0);
    check("mid_rst_b_busy", int'(busy_b), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(6);
    run_seq(16'h0001, 1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    idle(60);

    // Closed loop: five back-to-back requests into dut_b's receiver.
    idle(20);
    det_arm = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    idle(50);
    det_arm = 1'b0;
    check("cl_pulses", pulse_q.size(), CL_PRESSES);
    for (int i = 1; i < pulse_q.size(); i++) begin
      check("cl_spacing", pulse_q[i] - pulse_q[i-1], 7);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/press_pulse_gen.md
Name: press_pulse_gen

Overview:
- Transmit side of the press/edge-detect interface.
- Converts single-cycle event requests (from game logic, autoplay or test sequencer) into clean press-like level waveforms.
- Waveform: high for HIGH_CYCLES, then low for at least LOW_CYCLES.
- Downstream two-flop synchronizer plus rising-edge detector sees exactly one press per accepted request.

Parameters:
HIGH_CYCLES, 4, cycles out is held high per press; legal range >= 1.
LOW_CYCLES, 4, minimum cycles out is held low between presses; legal range >= 3, so the receiver's 2-flop sync observes the low.
MAX_PENDING, 3, depth of request backlog (used only with PRESS_QUEUE_EN); legal range >= 1.
PEND_W, $clog2(MAX_PENDING+1), width of pending count.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
trig  input  1  single-cycle press request, synchronous to clk.
out  output  1  generated press level; registered.
busy  output  1  1 while a press or its low gap is in progress; registered.
dropped  output  1  one-cycle pulse when a request is discarded; registered.
pending  output  PEND_W  queued requests not yet started; 0 without PRESS_QUEUE_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - out=0, busy=0, dropped=0, pending=0, state=IDLE, timer=0.
  - Applies immediately regardless of clock.
  - A press interrupted mid-high drops out to 0 at once; no gap is enforced after release.
- States: IDLE, HIGH, GAP. Down-counter timer sized for max(HIGH_CYCLES, LOW_CYCLES).
- IDLE:
  - out=0, busy=0.
  - trig=1 -> HIGH, timer=HIGH_CYCLES-1.
  - Latency: out=1 in the cycle after the edge that samples trig.
- HIGH:
  - out=1, busy=1.
  - timer>0 -> decrement.
  - timer==0 -> GAP, timer=LOW_CYCLES-1.
  - out is high for exactly HIGH_CYCLES cycles.
- GAP:
  - out=0, busy=1.
  - timer>0 -> decrement.
  - timer==0 -> if pending>0 or trig=1: HIGH, timer=HIGH_CYCLES-1; else IDLE.
  - out is low for exactly LOW_CYCLES cycles between back-to-back presses.
- trig while HIGH or GAP, except the GAP-exit cycle: handled per PRESS_QUEUE_EN.
- Simultaneous events on the GAP-exit cycle:
  - trig=1, pending=0: trig is consumed directly; no IDLE cycle, pending unchanged.
  - trig=1, pending>0: one queued request is dequeued and trig is enqueued; net pending unchanged; never drops.
- dropped:
  - Asserted for exactly one cycle, the cycle after the discarded trig.
  - Multiple drops in consecutive cycles give consecutive dropped cycles.
- busy equals (state != IDLE) on the registered state; goes 0 the same cycle out enters IDLE.
- trig held high for N cycles counts as N requests; the upstream source is responsible for single-cycle pulses.

Optional Feature:
- Macro: PRESS_QUEUE_EN.
- Defined:
  - trig while busy (not the GAP-exit cycle) increments pending when pending<MAX_PENDING; otherwise dropped pulses and pending holds at MAX_PENDING.
  - Each GAP exit with pending>0 decrements pending and starts a new press.
- Undefined:
  - No backlog; pending tied to 0.
  - Every trig while busy (except the GAP-exit cycle) pulses dropped.

Test Plan:
- Reset, single trig in IDLE (defaults) -> out high cycles 1..4 after trig, low 5..8, busy high cycles 1..8, back to IDLE with busy=0 at cycle 9; dropped never asserts.
- Mid-press async reset: trig, then drop reset to 0 two cycles into HIGH between clock edges -> out/busy fall to 0 immediately without a clock edge; after release, idle until next trig.
- PRESS_QUEUE_EN, trig at cycles 0,2,3,4,5 (MAX_PENDING=3) -> pending 1,2,3, trig@5 drops (dropped=1 at cycle 6); exactly 4 presses, each 4 high / 4 low, contiguous.
- Without PRESS_QUEUE_EN, trig at cycles 0 and 3 -> one press only; dropped=1 at cycle 4; pending stays 0.
- trig on GAP-exit cycle (cycle 8 after trig@0), pending=0 -> out rises at cycle 9 with no IDLE cycle between presses; busy stays 1 throughout.
- Closed loop: drive out into the two-flop synchronizer and rising-edge detector that consume this interface, with 5 queued requests (MAX_PENDING=5, LOW_CYCLES=3) -> detector emits exactly 5 single-cycle pulses, spaced HIGH_CYCLES+LOW_CYCLES=7 cycles apart.
